// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared encodings for the proc_control sequencer
package proc_pkg;

    localparam int INSTR_W = 16;

    // Instruction field bit positions: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm8
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_RSB = 2'd2;

    function automatic logic [INSTR_W-1:0] sext8(input logic [7:0] v);
        return {{(INSTR_W-8){v[7]}}, v};
    endfunction

endpackage

// File: rtl/proc_decode.sv
// rtl/proc_decode.sv - combinational instruction decoder
// Ports: ir in; register selects, write-back source, ALU opcode, immediates,
// instruction class flags and legal flag out.
module proc_decode
    import proc_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [1:0]         a_sel,
    output logic [1:0]         b_sel,
    output logic [1:0]         wr_sel,
    output logic [1:0]         wb_src,
    output logic [2:0]         alu_op,
    output logic [INSTR_W-1:0] imm,
    output logic [7:0]         imm8,
    output logic               writes,
    output logic               is_alu,
    output logic               is_jmp,
    output logic               is_jz,
    output logic               is_halt,
    output logic               legal
);

    logic [3:0] opcode;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign a_sel  = ir[RD_MSB:RD_LSB];
    assign b_sel  = ir[RS_MSB:RS_LSB];
    assign wr_sel = ir[RD_MSB:RD_LSB];
    assign imm8   = ir[IMM_MSB:IMM_LSB];
    assign imm    = sext8(ir[IMM_MSB:IMM_LSB]);

    always_comb begin
        wb_src  = WB_ALU;
        alu_op  = ALU_ADD;
        writes  = 1'b0;
        is_alu  = 1'b0;
        is_jmp  = 1'b0;
        is_jz   = 1'b0;
        is_halt = 1'b0;
        legal   = 1'b1;
        case (opcode)
            OP_NOP:  ;
            OP_LDI:  begin writes = 1'b1; wb_src = WB_IMM; end
            OP_MOV:  begin writes = 1'b1; wb_src = WB_RSB; end
            OP_ADD:  begin writes = 1'b1; is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:  begin writes = 1'b1; is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin writes = 1'b1; is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin writes = 1'b1; is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_XOR:  begin writes = 1'b1; is_alu = 1'b1; alu_op = ALU_XOR; end
            OP_JMP:  is_jmp  = 1'b1;
            OP_JZ:   is_jz   = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: legal   = 1'b0;
        endcase
    end

endmodule

// File: rtl/proc_control.sv
// rtl/proc_control.sv - multi-cycle fetch/decode/exec sequencer for the 16-bit datapath
// Ports: clk, rst (sync, active-high); imem_addr/imem_req/imem_valid/imem_data fetch
// handshake; alu_zero in; a_sel, b_sel, wr_sel, wr_en, wb_src, alu_op, imm, halted out.
// Optional macro PROC_CTRL_ILLEGAL_TRAP_EN adds the illegal output and traps A-E opcodes.
module proc_control
    import proc_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               alu_zero,
    output logic [1:0]         a_sel,
    output logic [1:0]         b_sel,
    output logic [1:0]         wr_sel,
    output logic               wr_en,
    output logic [1:0]         wb_src,
    output logic [2:0]         alu_op,
    output logic [INSTR_W-1:0] imm,
    output logic               halted
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    logic illegal_q, illegal_d;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               zf_q, zf_d;
    logic [1:0]         a_sel_q, a_sel_d, b_sel_q, b_sel_d, wr_sel_q, wr_sel_d;
    logic [1:0]         wb_src_q, wb_src_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [INSTR_W-1:0] imm_q, imm_d;
    logic               wr_en_q, wr_en_d;
    logic               imem_req_q, imem_req_d;
    logic               halted_q, halted_d;

    logic [1:0]         dec_a_sel, dec_b_sel, dec_wr_sel, dec_wb_src;
    logic [2:0]         dec_alu_op;
    logic [INSTR_W-1:0] dec_imm;
    logic [7:0]         dec_imm8;
    logic               dec_writes, dec_is_alu, dec_is_jmp, dec_is_jz, dec_is_halt, dec_legal;
    logic               fetch_acc;

    // The decoder looks at ir_d so the selects can be registered on the
    // accept edge and are already valid during DECODE; in DECODE/EXEC
    // ir_d equals ir_q, so the same decode drives the EXEC decisions.
    assign fetch_acc = (state_q == ST_FETCH) && imem_req_q && imem_valid;
    assign ir_d      = fetch_acc ? imem_data : ir_q;

    proc_decode u_decode (
        .ir      (ir_d),
        .a_sel   (dec_a_sel),
        .b_sel   (dec_b_sel),
        .wr_sel  (dec_wr_sel),
        .wb_src  (dec_wb_src),
        .alu_op  (dec_alu_op),
        .imm     (dec_imm),
        .imm8    (dec_imm8),
        .writes  (dec_writes),
        .is_alu  (dec_is_alu),
        .is_jmp  (dec_is_jmp),
        .is_jz   (dec_is_jz),
        .is_halt (dec_is_halt),
        .legal   (dec_legal)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        zf_d       = zf_q;
        a_sel_d    = a_sel_q;
        b_sel_d    = b_sel_q;
        wr_sel_d   = wr_sel_q;
        wb_src_d   = wb_src_q;
        alu_op_d   = alu_op_q;
        imm_d      = imm_q;
        wr_en_d    = 1'b0;
        imem_req_d = imem_req_q;
        halted_d   = halted_q;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif
        unique case (state_q)
            ST_FETCH: begin
                if (fetch_acc) begin
                    pc_d       = pc_q + PC_W'(1);
                    state_d    = ST_DECODE;
                    imem_req_d = 1'b0;
                    a_sel_d    = dec_a_sel;
                    b_sel_d    = dec_b_sel;
                    wr_sel_d   = dec_wr_sel;
                    wb_src_d   = dec_wb_src;
                    alu_op_d   = dec_alu_op;
                    imm_d      = dec_imm;
                end else begin
                    // Covers the first FETCH cycle after reset, where req is still low.
                    imem_req_d = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXEC;
                wr_en_d = dec_writes;
            end
            ST_EXEC: begin
                if (dec_is_alu) begin
                    zf_d = alu_zero;
                end
                // JZ reads zf_q: the flag as it stood before this instruction.
                if (dec_is_jmp || (dec_is_jz && zf_q)) begin
                    pc_d = PC_W'(dec_imm8);
                end
                if (dec_is_halt || (TRAP_EN && !dec_legal)) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                    illegal_d = illegal_q | !dec_legal;
`endif
                end else begin
                    state_d    = ST_FETCH;
                    imem_req_d = 1'b1;
                end
            end
            ST_HALT: begin
                imem_req_d = 1'b0;
                halted_d   = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            zf_q       <= 1'b0;
            a_sel_q    <= '0;
            b_sel_q    <= '0;
            wr_sel_q   <= '0;
            wb_src_q   <= '0;
            alu_op_q   <= '0;
            imm_q      <= '0;
            wr_en_q    <= 1'b0;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b0;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            zf_q       <= zf_d;
            a_sel_q    <= a_sel_d;
            b_sel_q    <= b_sel_d;
            wr_sel_q   <= wr_sel_d;
            wb_src_q   <= wb_src_d;
            alu_op_q   <= alu_op_d;
            imm_q      <= imm_d;
            wr_en_q    <= wr_en_d;
            imem_req_q <= imem_req_d;
            halted_q   <= halted_d;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    assign imem_addr = pc_q;
    assign imem_req  = imem_req_q;
    assign a_sel     = a_sel_q;
    assign b_sel     = b_sel_q;
    assign wr_sel    = wr_sel_q;
    assign wr_en     = wr_en_q;
    assign wb_src    = wb_src_q;
    assign alu_op    = alu_op_q;
    assign imm       = imm_q;
    assign halted    = halted_q;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    assign illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_proc_control.sv
// tb/tb_proc_control.sv - self-checking bench for proc_control
module tb_proc_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        alu_zero;
    logic [1:0]  a_sel, b_sel, wr_sel, wb_src;
    logic        wr_en;
    logic [2:0]  alu_op;
    logic [15:0] imm;
    logic        halted;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    always #5 clk = ~clk;

    proc_control #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .alu_zero   (alu_zero),
        .a_sel      (a_sel),
        .b_sel      (b_sel),
        .wr_sel     (wr_sel),
        .wr_en      (wr_en),
        .wb_src     (wb_src),
        .alu_op     (alu_op),
        .imm        (imm),
        .halted     (halted)
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal    (illegal)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory and responder state
    logic [15:0] mem [256];
    int          wait_cycles = 0;
    bit          glitch = 1'b1;
    int          wcnt = 0;

    // ISA-level model state
    logic [7:0]  m_pc;
    logic        m_zf, m_halted, m_illegal;
    int          cyc, acc, reqlen;
    logic        prev_req;
    logic [1:0]  e_a, e_b, e_wb;
    logic [2:0]  e_alu;
    logic [15:0] e_imm;
    logic        e_write = 1'b0;

    // Observations used by the hand-computed checks
    int          wr_count;
    logic [1:0]  last_wr_sel, last_wb;
    logic [2:0]  last_alu;
    logic [15:0] last_imm;
    int          rises[$];
    int          fh[$];

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic model_exec(input logic [15:0] ins);
        logic [3:0] op;
        op      = ins[15:12];
        e_a     = ins[11:10];
        e_b     = ins[9:8];
        e_write = (op >= 4'h1) && (op <= 4'h7);
        e_wb    = (op == 4'h1) ? 2'd1 : (op == 4'h2) ? 2'd2 : 2'd0;
        e_alu   = ((op >= 4'h3) && (op <= 4'h7)) ? 3'(op - 4'h3) : 3'd0;
        e_imm   = {{8{ins[7]}}, ins[7:0]};
        m_pc    = m_pc + 8'd1;
        if (op == 4'h8 || (op == 4'h9 && m_zf)) m_pc = ins[7:0];
        if (op >= 4'h3 && op <= 4'h7) m_zf = alu_zero;
        if (op == 4'hF) m_halted = 1'b1;
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        if (op >= 4'hA && op <= 4'hE) begin
            m_halted  = 1'b1;
            m_illegal = 1'b1;
        end
`endif
    endtask

    // Memory responder: answers wait_cycles cycles after imem_req rises,
    // and waves a stray imem_valid around while no request is pending.
    initial begin
        imem_valid = 1'b0;
        imem_data  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && imem_req) begin
                if (wcnt >= wait_cycles) begin
                    imem_valid = 1'b1;
                    imem_data  = mem[imem_addr];
                end else begin
                    imem_valid = 1'b0;
                    imem_data  = 16'h1FFF;
                end
                wcnt++;
            end else begin
                wcnt       = 0;
                imem_valid = glitch;
                imem_data  = 16'h1FFF;
            end
        end
    end

    // Compare process: checks every cycle against the ISA model and the
    // 3-cycle fetch/decode/exec timing rules.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_pc = 8'h00; m_zf = 1'b0; m_halted = 1'b0; m_illegal = 1'b0;
                cyc = 0; acc = -100; reqlen = 0; prev_req = 1'b0; e_write = 1'b0;
            end else begin
                cyc++;
                chk("halted", halted, m_halted && (cyc >= acc + 3));
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
                chk("illegal", illegal, m_illegal && (cyc >= acc + 3));
`endif
                if (cyc == acc + 1 || cyc == acc + 2 || (m_halted && cyc >= acc + 3))
                    chk("req_idle", imem_req, 1'b0);
                if (cyc == acc + 3 && !m_halted)
                    chk("req_next", imem_req, 1'b1);
                chk("wr_en", wr_en, (cyc == acc + 2) && e_write);
                if (cyc == acc + 1 || cyc == acc + 2) begin
                    chk("a_sel", a_sel, e_a);
                    chk("b_sel", b_sel, e_b);
                    chk("wr_sel", wr_sel, e_a);
                    chk("wb_src", wb_src, e_wb);
                    chk("alu_op", alu_op, e_alu);
                    chk("imm", imm, e_imm);
                end
                if (wr_en) begin
                    wr_count++;
                    last_wr_sel = wr_sel;
                    last_wb     = wb_src;
                    last_alu    = alu_op;
                    last_imm    = imm;
                end
                if (imem_req) begin
                    chk("imem_addr", imem_addr, m_pc);
                    reqlen++;
                    if (!prev_req) rises.push_back(cyc);
                end
                prev_req = imem_req;
                if (imem_req && imem_valid) begin
                    chk("req_len", reqlen, wait_cycles + 1);
                    reqlen = 0;
                    fh.push_back(int'(m_pc));
                    model_exec(imem_data);
                    acc = cyc;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 8'h00);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_sels", {a_sel, b_sel, wr_sel, wb_src, alu_op}, 0);
        chk("rst_imm", imm, 16'h0000);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        chk("rst_illegal", illegal, 1'b0);
`endif
        wr_count = 0;
        rises.delete();
        fh.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_low", imem_req, 1'b0);
        @(negedge clk);
        chk("fetch_resumes", imem_req, 1'b1);
    endtask

    task automatic run_prog(input string name, input int budget);
        int n;
        do_reset();
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!halted) begin
            bad++;
            $display("FAIL %s_timeout: halted=%0b expected 1", name, halted);
        end
        repeat (20) @(negedge clk);
        chk({name, "_hold_req"}, imem_req, 1'b0);
        chk({name, "_hold_halted"}, halted, 1'b1);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        alu_zero = 1'b0;
        fill_mem();

        // Reset while a stalled fetch at 0x40 has imem_req high
        wait_cycles = 5;
        mem[8'h00] = 16'h8040;
        mem[8'h40] = 16'h0000;
        do_reset();
        n = 0;
        while (!(imem_req && imem_addr == 8'h40) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midfetch_reached", imem_addr, 8'h40);
        repeat (2) @(negedge clk);
        do_reset();

        // LDI r2,#0xFE then HALT
        wait_cycles = 0;
        fill_mem();
        mem[0] = 16'h18FE;
        run_prog("ldi", 60);
        chk("ldi_wr_count", wr_count, 1);
        chk("ldi_wr_sel", last_wr_sel, 2'd2);
        chk("ldi_wb_src", last_wb, 2'd1);
        chk("ldi_imm", last_imm, 16'hFFFE);
        chk("ldi_fetch1", qget(fh, 1), 1);
        chk("ldi_pc", imem_addr, 8'h02);
        chk("ldi_cpi", qget(rises, 1) - qget(rises, 0), 3);

        // SUB r1,r1 then JZ #0x20, taken and not taken
        fill_mem();
        mem[0] = 16'h4500;
        mem[1] = 16'h9020;
        mem[2] = 16'h1001;
        alu_zero = 1'b1;
        run_prog("jz_taken", 80);
        chk("jz_taken_pc", imem_addr, 8'h21);
        chk("jz_taken_wr", wr_count, 1);
        chk("jz_sub_alu", last_alu, 3'd1);
        alu_zero = 1'b0;
        run_prog("jz_not", 80);
        chk("jz_not_pc", imem_addr, 8'h04);
        chk("jz_not_wr", wr_count, 2);

        // Fetch delayed by three cycles
        wait_cycles = 3;
        fill_mem();
        mem[0] = 16'h0000;
        run_prog("wait3", 80);
        chk("wait3_cpi", qget(rises, 1) - qget(rises, 0), 6);
        wait_cycles = 0;

        // PC wrap 0xFF -> 0x00, JZ not taken then taken
        fill_mem();
        mem[8'h00] = 16'h9005;
        mem[8'h01] = 16'h4000;
        mem[8'h02] = 16'h80FF;
        mem[8'hFF] = 16'h0000;
        alu_zero = 1'b1;
        run_prog("wrap", 120);
        chk("wrap_ff", qget(fh, 3), 8'hFF);
        chk("wrap_00", qget(fh, 4), 8'h00);
        chk("wrap_pc", imem_addr, 8'h06);

        // Mixed LDI/MOV/ALU/JMP program
        fill_mem();
        mem[0] = 16'h1F7F;
        mem[1] = 16'h2700;
        mem[2] = 16'h3900;
        mem[3] = 16'h5600;
        mem[4] = 16'h6C00;
        mem[5] = 16'h7000;
        mem[6] = 16'h8009;
        alu_zero = 1'b0;
        run_prog("mixed", 150);
        chk("mixed_wr", wr_count, 6);
        chk("mixed_pc", imem_addr, 8'h0A);

        // Illegal opcode 0xA000
        fill_mem();
        mem[0] = 16'hA000;
        run_prog("illegal", 60);
        chk("illegal_wr", wr_count, 0);
`ifdef PROC_CTRL_ILLEGAL_TRAP_EN
        chk("illegal_pc", imem_addr, 8'h01);
        chk("illegal_flag", illegal, 1'b1);
`else
        chk("illegal_pc", imem_addr, 8'h02);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
